// File: rtl/jtkunio_gfx_pkg.sv
// rtl/jtkunio_gfx_pkg.sv - shared constants, FSM encoding and round-robin helper for the gfx ROM arbiter
// Contents: requester indices (char, scroll, object), fetch FSM states, data width,
// and the mod-3 successor used by the round-robin search.
package jtkunio_gfx_pkg;

  localparam int DW = 32;

  localparam logic [1:0] REQ_CHAR = 2'd0;
  localparam logic [1:0] REQ_SCR  = 2'd1;
  localparam logic [1:0] REQ_OBJ  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } fetch_state_e;

  // Successor modulo 3; the unused code 3 folds back to char.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= REQ_OBJ) ? REQ_CHAR : idx + 2'd1;
  endfunction

endpackage

// File: rtl/jtkunio_gfx_cache.sv
// rtl/jtkunio_gfx_cache.sv - one-word ROM cache with tag compare and fill port
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   cs                    : requester enable (gates ok and miss)
//   addr [AW]             : requester word address
//   fill_en, fill_addr,
//   fill_data             : write port, loads tag/data and sets valid
//   data [32], ok, miss   : cached word, hit for current addr, pending fetch
module jtkunio_gfx_cache
  import jtkunio_gfx_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          fill_en,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  output logic [DW-1:0] data,
  output logic          ok,
  output logic          miss
);

  logic [AW-1:0] tag_q, tag_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          hit;

  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (fill_en) begin
      tag_d   = fill_addr;
      data_d  = fill_data;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Compare against the live address so ok drops the same cycle addr moves.
  assign hit  = valid_q && (tag_q == addr);
  assign ok   = hit && cs;
  assign miss = cs && !hit;
  assign data = data_q;

endmodule

// File: rtl/jtkunio_gfx_arb.sv
// rtl/jtkunio_gfx_arb.sv - shares one graphics ROM port between char, scroll and object fetchers
// Ports:
//   clk, rst_n                    : clock, synchronous active-low reset
//   char_addr/char_data/char_ok   : char private ROM interface (always enabled)
//   scr_addr/scr_data/scr_ok      : scroll private ROM interface (always enabled)
//   obj_cs/obj_addr/obj_data/obj_ok : object private ROM interface
//   mem_req/mem_addr/mem_ack      : shared port request, held until ack
//   mem_rdy/mem_data              : shared port read return (one-cycle pulse)
module jtkunio_gfx_arb
  import jtkunio_gfx_pkg::*;
#(
  parameter logic [21:0] CHAR_OFFSET = 22'h00000,
  parameter logic [21:0] SCR_OFFSET  = 22'h04000,
  parameter logic [21:0] OBJ_OFFSET  = 22'h24000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [13:0]   char_addr,
  output logic [DW-1:0] char_data,
  output logic          char_ok,
  input  logic [16:0]   scr_addr,
  output logic [DW-1:0] scr_data,
  output logic          scr_ok,
  input  logic          obj_cs,
  input  logic [17:0]   obj_addr,
  output logic [DW-1:0] obj_data,
  output logic          obj_ok,
  output logic          mem_req,
  output logic [21:0]   mem_addr,
  input  logic          mem_ack,
  input  logic          mem_rdy,
  input  logic [DW-1:0] mem_data
);

  fetch_state_e state_q, state_d;
  logic [1:0]   last_q, last_d;
  logic [1:0]   gnt_q, gnt_d;
  logic         mem_req_q, mem_req_d;
  logic [21:0]  mem_addr_q, mem_addr_d;
  logic [17:0]  lat_q, lat_d;      // requester-space address of the fetch in flight
  logic [2:0]   miss, fill_en;
  logic [1:0]   c0, c1, c2, win;
  logic [21:0]  win_mem_addr;
  logic [17:0]  win_lat;
  logic         fill;

  function automatic logic pend(input logic [2:0] m, input logic [1:0] i);
    case (i)
      REQ_CHAR: pend = m[0];
      REQ_SCR:  pend = m[1];
      default:  pend = m[2];
    endcase
  endfunction

  jtkunio_gfx_cache #(.AW(14)) u_char (
    .clk(clk), .rst_n(rst_n), .cs(1'b1), .addr(char_addr),
    .fill_en(fill_en[0]), .fill_addr(lat_q[13:0]), .fill_data(mem_data),
    .data(char_data), .ok(char_ok), .miss(miss[0])
  );

  jtkunio_gfx_cache #(.AW(17)) u_scr (
    .clk(clk), .rst_n(rst_n), .cs(1'b1), .addr(scr_addr),
    .fill_en(fill_en[1]), .fill_addr(lat_q[16:0]), .fill_data(mem_data),
    .data(scr_data), .ok(scr_ok), .miss(miss[1])
  );

  jtkunio_gfx_cache #(.AW(18)) u_obj (
    .clk(clk), .rst_n(rst_n), .cs(obj_cs), .addr(obj_addr),
    .fill_en(fill_en[2]), .fill_addr(lat_q), .fill_data(mem_data),
    .data(obj_data), .ok(obj_ok), .miss(miss[2])
  );

  // Round-robin: search starts one past the last grant; c2 is the fallback
  // and is only used when something is pending.
  always_comb begin
    c0  = rr_next(last_q);
    c1  = rr_next(c0);
    c2  = rr_next(c1);
    win = pend(miss, c0) ? c0 : (pend(miss, c1) ? c1 : c2);
    case (win)
      REQ_CHAR: begin
        win_mem_addr = {8'd0, char_addr} + CHAR_OFFSET;
        win_lat      = {4'd0, char_addr};
      end
      REQ_SCR: begin
        win_mem_addr = {5'd0, scr_addr} + SCR_OFFSET;
        win_lat      = {1'b0, scr_addr};
      end
      default: begin
        win_mem_addr = {4'd0, obj_addr} + OBJ_OFFSET;
        win_lat      = obj_addr;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    lat_d      = lat_q;
    fill       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|miss) begin
          gnt_d      = win;
          last_d     = win;
          lat_d      = win_lat;
          mem_addr_d = win_mem_addr;
          mem_req_d  = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          // Data may come back with the ack; skip WAIT in that case.
          if (mem_rdy) begin
            fill    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_rdy) begin
          fill    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_q     <= REQ_OBJ;
      gnt_q      <= REQ_CHAR;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      lat_q      <= lat_d;
    end
  end

  assign fill_en[0] = fill && (gnt_q == REQ_CHAR);
  assign fill_en[1] = fill && (gnt_q == REQ_SCR);
  assign fill_en[2] = fill && (gnt_q == REQ_OBJ);
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

endmodule

// File: doc/jtkunio_gfx_arb.md
# jtkunio_gfx_arb

Shares one 32-bit graphics ROM read port between the three video layer fetchers (char, scroll, object) in the Kunio video subsystem. Each requester sees a private ROM interface (address in, data/ok out) backed by a one-word cache; misses are queued to the shared memory port through a round-robin arbiter and a three-state fetch FSM. Sits between the layer modules inside the video top and the SDRAM controller's graphics slot.

## Interface
- `CHAR_OFFSET`, 22'h00000: word offset of char ROM in the shared space.
- `SCR_OFFSET`, 22'h04000: word offset of scroll ROM.
- `OBJ_OFFSET`, 22'h24000: word offset of object ROM.
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `char_addr` in 14: char word address.
- `char_data` out 32: char word.
- `char_ok` out 1: `char_data` valid for the current `char_addr`.
- `scr_addr` in 17: scroll word address.
- `scr_data` out 32: scroll word.
- `scr_ok` out 1: `scr_data` valid.
- `obj_cs` in 1: object fetch enable; char and scroll are always enabled.
- `obj_addr` in 18: object word address.
- `obj_data` out 32: object word.
- `obj_ok` out 1: `obj_data` valid.
- `mem_req` out 1: shared-port request; held until `mem_ack`.
- `mem_addr` out 22: offset-added word address; stable while `mem_req` is high.
- `mem_ack` in 1: request accepted.
- `mem_rdy` in 1: one-cycle pulse, `mem_data` valid.
- `mem_data` in 32: read data.

## Operation
- Per requester cache:
  - Registered `tag` (address width), `data` (32) and `valid`.
  - `ok = valid && tag == addr && cs`. This is combinational on the address, so `ok` drops in the same cycle the address changes.
- Pending: `miss[i] = cs && !(valid && tag == addr)`.
- Arbiter: round-robin over {char=0, scr=1, obj=2}.
  - A 2-bit `last` register holds the last granted index.
  - Search order starts at `last+1` mod 3.
  - `last` updates only when the grant is issued.
- FSM states:
  - IDLE: if any `miss`, latch the winner index and `mem_addr = addr + OFFSET` (22-bit add, no saturation, wraps mod 2^22), set `mem_req`, go to ISSUE.
  - ISSUE: hold `mem_req`/`mem_addr`. On `mem_ack`, drop `mem_req` and go to WAIT.
  - WAIT: on `mem_rdy`, write `mem_data` and the latched address into the granted cache, set `valid`, go to IDLE.
- Address-change race: if the requester's address changes during ISSUE or WAIT, the fetch still completes. The cache is filled with the latched (old) address, so `ok` stays low and a new miss is raised from IDLE.
- `obj_cs` low: obj `ok` is 0. An in-flight obj fetch still completes and fills the cache.
- `mem_ack` and `mem_rdy` in the same cycle in ISSUE: treat as ack+rdy. Fill the cache and go to IDLE directly.
- `mem_rdy` outside WAIT (or outside the same-cycle case above) is ignored.
- Reset: all `valid`=0, tags=0, data=0, `last`=2 (so char is first), FSM=IDLE, `mem_req`=0, `mem_addr`=0. All `ok`=0.
- Reset mid-fetch: abandon the fetch. Any `mem_rdy` arriving after reset is ignored because the FSM is in IDLE.

## Timing
- Miss detected in cycle N (FSM in IDLE) → `mem_req` high and `mem_addr` valid from cycle N+1.
- `mem_ack` in cycle A → `mem_req` low from A+1.
- `mem_rdy` in cycle R → cache written at the R edge → `ok` and `data` valid from R+1.
- Minimum miss-to-ok with same-cycle ack+rdy at N+1: `ok` at N+2.
- Hit: `ok` is combinational, 0 added cycles.
- Back-to-back: the next grant's `mem_req` rises at earliest one cycle after the fill (IDLE re-evaluates in R+1, `mem_req` at R+2).
- Starvation bound: a requester that stays pending is served within 3 grants.

## Structure
- Shared package `jtkunio_gfx_pkg`: requester index constants (CHAR=0, SCR=1, OBJ=2) and FSM state encodings (IDLE, ISSUE, WAIT).
- One sub-module `jtkunio_gfx_cache`, parameterised on address width and instantiated three times. It provides tag/data/valid, hit compare and the fill port.
- Arbiter and FSM live in the top module.

## Test plan
- Reset, then `char_addr`=0x0010 with the memory model acking in 1 cycle and returning in 3 → `mem_addr`=0x000010, `char_ok` high 5 cycles after the request with `char_data` = model word. Hold the address → no further `mem_req`.
- `scr_addr`=0x00001 → `mem_addr`=0x04001. `obj_cs`=1, `obj_addr`=0x00002 → `mem_addr`=0x24002. `obj_addr`=0x3FFFF with `OBJ_OFFSET`=22'h3C0001 → `mem_addr` wraps to 0x000000.
- All three miss in the same cycle after reset → grant order char, scr, obj. Then all miss again → order char, scr, obj (rotation from `last`=obj).
- `char_addr` changes from 0x10 to 0x20 during WAIT → first fill leaves `char_ok`=0, a second `mem_req` with `mem_addr`=0x20 follows, then `char_ok`=1.
- Same-cycle `mem_ack`+`mem_rdy` → fill in that cycle, `ok` next cycle, `mem_req` low. A spurious `mem_rdy` while in IDLE changes no cache.
- `rst_n` low during WAIT for 1 cycle → all `ok`=0 and `mem_req`=0. A late `mem_rdy` is ignored. The next miss is served from IDLE normally.
